// File: rtl/keccak_sponge_driver.sv
// Sponge-side driver for a Keccak permutation core: packs lanes into padded rate blocks,
// issues absorb/squeeze requests and streams the squeezed rate. Optional: KECCAK_DRV_BLOCK_COUNT_EN.
module keccak_sponge_driver #(
  parameter int RATE       = 128,
  parameter int W          = 16,
  parameter int OUT_BLOCKS = 1
) (
  input  logic                   ClkxCI,
  input  logic                   RstxRBI,
  input  logic                   MsgValidxSI,
  input  logic                   MsgLastxSI,
  input  logic [$clog2(W+1)-1:0] MsgBitsxDI,
  input  logic [W-1:0]           MsgDataxDI,
  output logic                   MsgReadyxSO,
  input  logic                   CoreReadyxSI,
  output logic                   StartAbsorbxSO,
  output logic                   StartSqueezexSO,
  output logic [RATE-1:0]        DataxDO,
  input  logic [RATE-1:0]        StateRatexDI,
  output logic                   OutValidxSO,
  output logic [W-1:0]           OutDataxDO,
  input  logic                   OutReadyxSI,
  output logic                   DonexSO
`ifdef KECCAK_DRV_BLOCK_COUNT_EN
  ,
  output logic [15:0]            BlockCntxDO
`endif
);

  localparam int L  = RATE / W;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int BW = $clog2(W + 1);

  typedef enum logic [2:0] {
    COLLECT, ABSORB_REQ, ABSORB_WAIT, PAD, SQ_OUT, SQ_REQ, SQ_WAIT
  } state_e;

  state_e          state_q;
  logic [RATE-1:0] buf_q;
  logic [CW-1:0]   slot_q;
  logic [CW-1:0]   lane_q;
  logic [15:0]     sqCnt_q;
  logic            final_q, pendPad_q, padBit0_q, skip_q;
  logic            msgReady_q, outValid_q, done_q;

  logic [W-1:0]    padLane_d;
  logic [W-1:0]    outLane_d;
  logic            lastSlot_d, fullLane_d, tailPad_d, fullEnd_d;
  int              padPos_d;

  // Final lane keeps bits below b and places the pad-start 1 at bit b (nothing when b == W).
  always_comb begin
    padLane_d = '0;
    outLane_d = '0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(MsgBitsxDI))       padLane_d[i] = MsgDataxDI[i];
      else if (i == int'(MsgBitsxDI)) padLane_d[i] = 1'b1;
    end
    for (int i = 0; i < L; i++) begin
      if (lane_q == CW'(i)) outLane_d = StateRatexDI[i*W +: W];
    end
    lastSlot_d = (slot_q == CW'(L - 1));
    fullLane_d = (MsgBitsxDI == BW'(W));
    padPos_d   = int'(slot_q) * W + int'(MsgBitsxDI);
    tailPad_d  = !fullLane_d && (padPos_d == RATE - 1);
    fullEnd_d  = fullLane_d && lastSlot_d;
  end

  assign MsgReadyxSO     = msgReady_q;
  assign DataxDO         = buf_q;
  assign OutValidxSO     = outValid_q;
  assign OutDataxDO      = outValid_q ? outLane_d : '0;
  assign DonexSO         = done_q;
  assign StartAbsorbxSO  = (state_q == ABSORB_REQ) && CoreReadyxSI;
  assign StartSqueezexSO = (state_q == SQ_REQ) && CoreReadyxSI;

  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI) begin
      state_q    <= COLLECT;
      buf_q      <= '0;
      slot_q     <= '0;
      lane_q     <= '0;
      sqCnt_q    <= '0;
      final_q    <= 1'b0;
      pendPad_q  <= 1'b0;
      padBit0_q  <= 1'b0;
      skip_q     <= 1'b0;
      msgReady_q <= 1'b0;
      outValid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          msgReady_q <= 1'b1;
          if (MsgValidxSI && msgReady_q) begin
            for (int i = 0; i < L; i++) begin
              if (slot_q == CW'(i)) buf_q[i*W +: W] <= MsgLastxSI ? padLane_d : MsgDataxDI;
            end
            if (!MsgLastxSI) begin
              slot_q <= lastSlot_d ? '0 : slot_q + 1'b1;
              if (lastSlot_d) begin
                final_q    <= 1'b0;
                pendPad_q  <= 1'b0;
                msgReady_q <= 1'b0;
                state_q    <= ABSORB_REQ;
              end
            end else begin
              slot_q     <= '0;
              msgReady_q <= 1'b0;
              state_q    <= ABSORB_REQ;
              if (tailPad_d || fullEnd_d) begin
                final_q   <= 1'b0;
                pendPad_q <= 1'b1;
                padBit0_q <= fullEnd_d;
              end else begin
                final_q <= 1'b1;
                // A full final lane pushes the pad-start 1 into the next slot.
                for (int i = 1; i < L; i++) begin
                  if (fullLane_d && slot_q == CW'(i - 1)) buf_q[i*W] <= 1'b1;
                end
                buf_q[RATE-1] <= 1'b1;
              end
            end
          end
        end
        ABSORB_REQ: begin
          if (CoreReadyxSI) begin
            buf_q   <= '0;
            skip_q  <= 1'b1;
            state_q <= ABSORB_WAIT;
          end
        end
        ABSORB_WAIT: begin
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (CoreReadyxSI) begin
            if (final_q) begin
              state_q    <= SQ_OUT;
              outValid_q <= 1'b1;
              lane_q     <= '0;
              sqCnt_q    <= '0;
            end else if (pendPad_q) begin
              state_q <= PAD;
            end else begin
              state_q    <= COLLECT;
              msgReady_q <= 1'b1;
            end
          end
        end
        PAD: begin
          buf_q         <= '0;
          buf_q[RATE-1] <= 1'b1;
          buf_q[0]      <= padBit0_q;
          pendPad_q     <= 1'b0;
          final_q       <= 1'b1;
          state_q       <= ABSORB_REQ;
        end
        SQ_OUT: begin
          if (OutReadyxSI) begin
            if (lane_q == CW'(L - 1)) begin
              lane_q     <= '0;
              outValid_q <= 1'b0;
              if (int'(sqCnt_q) + 1 < OUT_BLOCKS) begin
                sqCnt_q <= sqCnt_q + 16'd1;
                state_q <= SQ_REQ;
              end else begin
                done_q     <= 1'b1;
                msgReady_q <= 1'b1;
                state_q    <= COLLECT;
              end
            end else begin
              lane_q <= lane_q + 1'b1;
            end
          end
        end
        SQ_REQ: begin
          if (CoreReadyxSI) begin
            skip_q  <= 1'b1;
            state_q <= SQ_WAIT;
          end
        end
        SQ_WAIT: begin
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (CoreReadyxSI) begin
            state_q    <= SQ_OUT;
            outValid_q <= 1'b1;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

`ifdef KECCAK_DRV_BLOCK_COUNT_EN
  logic [15:0] blkCnt_q;

  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI)                               blkCnt_q <= '0;
    else if (done_q)                            blkCnt_q <= '0;
    else if (StartAbsorbxSO && blkCnt_q != '1)  blkCnt_q <= blkCnt_q + 16'd1;
  end

  assign BlockCntxDO = blkCnt_q;
`endif

endmodule

// File: doc/keccak_sponge_driver.md
Name: keccak_sponge_driver

Overview:
- Host-side initiator for the Keccak permutation core's start/ready handshake.
- Packs an incoming lane stream into RATE-bit blocks and applies pad10*1.
- Issues absorb requests when the core is ready, then squeezes OUT_BLOCKS rate-blocks of output as a lane stream.
- Sits between the system message bus and the core; masking/share generation happens downstream of DataxDO.

Parameters:
RATE, 128, sponge rate in bits; multiple of W
W, 16, lane width in bits; lanes per block L = RATE/W
OUT_BLOCKS, 1, rate-blocks squeezed per message (>=1)

Ports:
ClkxCI  in  1  clock
RstxRBI  in  1  asynchronous active-low reset
MsgValidxSI  in  1  message lane valid
MsgLastxSI  in  1  current lane is the final one
MsgBitsxDI  in  clog2(W+1)  valid bits in the final lane (0..W); ignored unless MsgLastxSI
MsgDataxDI  in  W  lane; bit 0 is the first message bit
MsgReadyxSO  out  1  lane accepted when MsgValidxSI && MsgReadyxSO
CoreReadyxSI  in  1  core ready (idle)
StartAbsorbxSO  out  1  absorb request, one-cycle pulse
StartSqueezexSO  out  1  squeeze request, one-cycle pulse
DataxDO  out  RATE  padded block to absorb; lane i at bits [i*W +: W]
StateRatexDI  in  RATE  unmasked rate part of the core state
OutValidxSO  out  1  output lane valid
OutDataxDO  out  W  output lane
OutReadyxSI  in  1  output lane consumed
DonexSO  out  1  one-cycle pulse after the last output lane is consumed

Behaviour:
- Reset: all outputs 0; block buffer cleared; lane counter = 0; state COLLECT.
- Accepted lanes are written to buffer slot = lane counter; counter wraps L-1 -> 0.
- COLLECT: MsgReadyxSO=1.
  - Non-last lane filling slot L-1 -> ABSORB_REQ (block full, not final).
  - Last lane with b=MsgBitsxDI: bits >= b of that lane are cleared, then bit b is set (pad start).
    - b=W: the pad 1 goes to bit 0 of the next slot instead.
  - Final bit (RATE-1) is set when the pad-start bit lies below RATE-1 in the same block -> ABSORB_REQ, final.
  - Pad-start fills bit RATE-1 exactly (127-bit tail), or a full-lane last message ends at slot L-1: an extra block follows, all zero except bit RATE-1 (plus bit 0 in the second case). FSM marks pending-pad and goes ABSORB_REQ, non-final.
- PAD: entered after a non-final absorb when pending-pad is set. Loads the extra block, clears pending-pad -> ABSORB_REQ, final.
- ABSORB_REQ: MsgReadyxSO=0; DataxDO holds the buffer.
  - StartAbsorbxSO = CoreReadyxSI combinationally; the request is accepted on that edge -> ABSORB_WAIT.
- ABSORB_WAIT: ignores CoreReadyxSI for the first cycle, then waits for CoreReadyxSI=1. Buffer cleared.
  - Final -> SQ_OUT.
  - Pending-pad -> PAD.
  - Otherwise -> COLLECT.
- SQ_OUT: OutDataxDO = StateRatexDI lane k, OutValidxSO=1; k advances on OutReadyxSI.
  - After lane L-1: if blocks emitted < OUT_BLOCKS -> SQ_REQ; else pulse DonexSO -> COLLECT.
- SQ_REQ / SQ_WAIT: same handshake as ABSORB_REQ / ABSORB_WAIT, using StartSqueezexSO -> SQ_OUT.
- Never more than one start pulse per request; both start outputs never high together.
- DataxDO stable from ABSORB_REQ entry until acceptance.
- Reset mid-operation: return to the reset state immediately; no pulse is emitted.
- MsgValidxSI outside COLLECT: stalled (MsgReadyxSO=0), not dropped.

Optional Feature:
KECCAK_DRV_BLOCK_COUNT_EN
- Defined: adds output BlockCntxDO[15:0], the number of accepted absorb requests since the last DonexSO. Saturates at 0xFFFF; cleared on reset and one cycle after DonexSO.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Empty message (1 beat, last, bits=0), CoreReady=1 -> one absorb; DataxDO lane0=0x0001, lane7=0x8000, other lanes 0.
- 8 full lanes 0xAAAA, last=1 on lane 8, bits=16 -> absorb #1 all lanes 0xAAAA; absorb #2 lane0=0x0001, lane7=0x8000.
- 7 lanes 0x1234, last lane 0x7FFF with bits=15 -> absorb #1 lane7=0xFFFF; absorb #2 all 0 except lane7=0x8000.
- CoreReady held 0 for 20 cycles in ABSORB_REQ -> no StartAbsorb, MsgReady=0, DataxDO stable; CoreReady=1 -> exactly one pulse.
- OUT_BLOCKS=2, StateRate lanes = index, OutReady toggling -> lanes 0..7, one StartSqueeze pulse, lanes 0..7 again, DonexSO once.
- Reset asserted after 3 accepted lanes -> all outputs 0; new 1-lane message pads from slot 0.
